// File: rtl/axis_packetizer.sv
// Network-interface packetizer: turns an (x, y, len) descriptor plus a payload word
// stream into one AXIS packet, a header flit then len+1 payload flits with tlast.
package axis_pkg;
  localparam int AXIS_DATA_WIDTH = 32;

  typedef struct packed {
    logic                       tvalid;
    logic [AXIS_DATA_WIDTH-1:0] tdata;
    logic                       tlast;
  } axis_mosi_t;

  typedef struct packed {
    logic tready;
  } axis_miso_t;
endpackage

module axis_packetizer
  import axis_pkg::*;
#(
  parameter int  DATA_WIDTH              = AXIS_DATA_WIDTH,
  parameter int  MAX_ROUTERS_X           = 4,
  parameter int  MAX_ROUTERS_Y           = 4,
  parameter int  MAXIMUM_PACKAGES_NUMBER = 5,
  localparam int MAX_ROUTERS_X_WIDTH     = $clog2(MAX_ROUTERS_X),
  localparam int MAX_ROUTERS_Y_WIDTH     = $clog2(MAX_ROUTERS_Y),
  localparam int LEN_WIDTH               = $clog2(MAXIMUM_PACKAGES_NUMBER)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           desc_valid_i,
  output logic                           desc_ready_o,
  input  logic [MAX_ROUTERS_X_WIDTH-1:0] desc_x_i,
  input  logic [MAX_ROUTERS_Y_WIDTH-1:0] desc_y_i,
  input  logic [LEN_WIDTH-1:0]           desc_len_i,
  input  logic                           data_valid_i,
  output logic                           data_ready_o,
  input  logic [DATA_WIDTH-1:0]          data_i,
  output axis_mosi_t                     out_mosi_o,
  input  axis_miso_t                     out_miso_i,
  output logic [15:0]                    pkt_count_o,
  output logic                           busy_o
);

  localparam int X_W = MAX_ROUTERS_X_WIDTH;
  localparam int Y_W = MAX_ROUTERS_Y_WIDTH;
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(MAXIMUM_PACKAGES_NUMBER - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD
  } state_t;

  state_t                 r_state;
  logic                   r_tvalid;
  logic [DATA_WIDTH-1:0]  r_tdata;
  logic                   r_tlast;
  logic [15:0]            r_pkt_count;
  logic [LEN_WIDTH-1:0]   r_flit_cnt;
  logic [LEN_WIDTH-1:0]   r_len;
  logic [X_W-1:0]         r_x;
  logic [Y_W-1:0]         r_y;

  logic                   w_load_ok;
  logic                   w_desc_hs;
  logic                   w_data_hs;
  logic                   w_last_flit;
  logic [LEN_WIDTH-1:0]   w_len_clamped;

  function automatic logic [DATA_WIDTH-1:0] build_header(
    input logic [X_W-1:0]       x,
    input logic [Y_W-1:0]       y,
    input logic [LEN_WIDTH-1:0] len
  );
    logic [DATA_WIDTH-1:0] hdr;
    // NOTE: start from all-zero so every bit is assigned on every call; a partial
    // assignment in combinational code is exactly what infers a latch.
    hdr                                = '0;
    hdr[X_W-1:0]                       = x;
    hdr[X_W+Y_W-1:X_W]                 = y;
    hdr[X_W+Y_W+LEN_WIDTH-1:X_W+Y_W]   = len;
    return hdr;
  endfunction

  // The output register may accept a new flit when empty or draining this cycle.
  assign w_load_ok     = !r_tvalid || out_miso_i.tready;
  assign desc_ready_o  = !rst_i && (r_state == ST_IDLE)    && w_load_ok;
  assign data_ready_o  = !rst_i && (r_state == ST_PAYLOAD) && w_load_ok;
  assign w_desc_hs     = desc_valid_i && desc_ready_o;
  assign w_data_hs     = data_valid_i && data_ready_o;
  assign w_last_flit   = (r_flit_cnt == r_len);
  assign w_len_clamped = (desc_len_i > LEN_MAX) ? LEN_MAX : desc_len_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: every state register is reset here; there is no storage array, so
      // nothing is left to power up undefined.
      r_state     <= ST_IDLE;
      r_tvalid    <= 1'b0;
      r_tdata     <= '0;
      r_tlast     <= 1'b0;
      r_pkt_count <= '0;
      r_flit_cnt  <= '0;
      r_len       <= '0;
      r_x         <= '0;
      r_y         <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read in this block
      // sees the pre-edge value regardless of statement order.
      if (r_tvalid && out_miso_i.tready) begin
        r_tvalid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_desc_hs) begin
            r_x        <= desc_x_i;
            r_y        <= desc_y_i;
            r_len      <= w_len_clamped;
            r_tvalid   <= 1'b1;
            r_tdata    <= build_header(desc_x_i, desc_y_i, w_len_clamped);
            r_tlast    <= 1'b0;
            r_flit_cnt <= '0;
            r_state    <= ST_PAYLOAD;
          end
        end

        // Only reachable if a header load is ever deferred out of IDLE.
        ST_HEADER: begin
          if (w_load_ok) begin
            r_tvalid   <= 1'b1;
            r_tdata    <= build_header(r_x, r_y, r_len);
            r_tlast    <= 1'b0;
            r_flit_cnt <= '0;
            r_state    <= ST_PAYLOAD;
          end
        end

        ST_PAYLOAD: begin
          if (w_data_hs) begin
            r_tvalid   <= 1'b1;
            r_tdata    <= data_i;
            r_tlast    <= w_last_flit;
            r_flit_cnt <= r_flit_cnt + LEN_WIDTH'(1);
            if (w_last_flit) begin
              r_pkt_count <= r_pkt_count + 16'd1;
              r_state     <= ST_IDLE;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_mosi_o.tvalid = r_tvalid;
  assign out_mosi_o.tdata  = r_tdata;
  assign out_mosi_o.tlast  = r_tlast;
  assign pkt_count_o       = r_pkt_count;
  assign busy_o            = (r_state != ST_IDLE) || r_tvalid;

endmodule

// File: tb/tb_axis_packetizer.sv
// Self-checking bench for axis_packetizer: directed and randomized packets are
// compared beat-by-beat against an expected stream built from the packet rules.
module tb_axis_packetizer;
  import axis_pkg::*;

  localparam int BOUND = 200;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        desc_valid_i;
  logic        desc_ready_o;
  logic [1:0]  desc_x_i;
  logic [1:0]  desc_y_i;
  logic [2:0]  desc_len_i;
  logic        data_valid_i;
  logic        data_ready_o;
  logic [31:0] data_i;
  axis_mosi_t  out_mosi_o;
  axis_miso_t  out_miso_i;
  logic [15:0] pkt_count_o;
  logic        busy_o;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          rdy_mode = 0;
  logic [15:0] exp_count;

  beat_t       exp_q[$];
  beat_t       obs_q[$];
  int          obs_cyc[$];

  beat_t       r_prev_beat;
  logic        r_prev_stall;

  axis_packetizer dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .desc_valid_i (desc_valid_i),
    .desc_ready_o (desc_ready_o),
    .desc_x_i     (desc_x_i),
    .desc_y_i     (desc_y_i),
    .desc_len_i   (desc_len_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .data_i       (data_i),
    .out_mosi_o   (out_mosi_o),
    .out_miso_i   (out_miso_i),
    .pkt_count_o  (pkt_count_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // tready generator: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random.
  initial begin
    int pat = 0;
    out_miso_i = '1;
    forever begin
      @(posedge clk_i);
      #1;
      case (rdy_mode)
        1:       begin out_miso_i.tready = (pat == 0); pat = (pat + 1) % 3; end
        2:       out_miso_i.tready = 1'($urandom_range(0, 1));
        default: out_miso_i.tready = 1'b1;
      endcase
    end
  end

  // Output monitor: a beat transfers on the edge after a negedge seeing valid&&ready.
  always @(negedge clk_i) begin
    if (!rst_i && out_mosi_o.tvalid && out_miso_i.tready) begin
      obs_q.push_back({out_mosi_o.tdata, out_mosi_o.tlast});
      obs_cyc.push_back(cyc);
    end
  end

  // Protocol watch: stalled flits must hold, readies stay low under stall and never overlap.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      check("ready_exclusive", {desc_ready_o, data_ready_o} == 2'b11, 1'b0);
      if (r_prev_stall) begin
        check("stall_tvalid", out_mosi_o.tvalid, 1'b1);
        check("stall_hold", {out_mosi_o.tdata, out_mosi_o.tlast}, r_prev_beat);
      end
      if (out_mosi_o.tvalid && !out_miso_i.tready)
        check("stall_readies", {desc_ready_o, data_ready_o}, 2'b00);
    end
    r_prev_stall <= !rst_i && out_mosi_o.tvalid && !out_miso_i.tready;
    r_prev_beat  <= {out_mosi_o.tdata, out_mosi_o.tlast};
  end

  task automatic send_packet(input logic [1:0] x, input logic [1:0] y,
                             input logic [2:0] len, input bit rnd);
    logic [2:0]  cl;
    logic [31:0] hdr;
    logic [31:0] w;
    bit          ok;
    bit          first;
    cl  = (len > 3'd4) ? 3'd4 : len;
    hdr = 32'(x) | (32'(y) << 2) | (32'(cl) << 4);
    exp_q.push_back({hdr, 1'b0});

    desc_valid_i = 1'b1;
    desc_x_i     = x;
    desc_y_i     = y;
    desc_len_i   = len;
    ok = 1'b0;
    for (int t = 0; t < BOUND; t++) begin
      @(negedge clk_i);
      if (desc_ready_o) begin ok = 1'b1; break; end
    end
    check("desc_handshake", ok, 1'b1);
    @(posedge clk_i);
    #1;
    desc_valid_i = 1'b0;

    first = 1'b1;
    for (int i = 0; i <= int'(cl); i++) begin
      w = rnd ? $urandom : (32'hA1 + 32'(i));
      exp_q.push_back({w, (i == int'(cl))});
      data_valid_i = 1'b1;
      data_i       = w;
      ok = 1'b0;
      for (int t = 0; t < BOUND; t++) begin
        @(negedge clk_i);
        if (first) begin
          check("header_latency", {out_mosi_o.tvalid, out_mosi_o.tdata, out_mosi_o.tlast},
                {1'b1, hdr, 1'b0});
          first = 1'b0;
        end
        if (data_ready_o) begin ok = 1'b1; break; end
      end
      check("data_handshake", ok, 1'b1);
      @(posedge clk_i);
      #1;
    end
    data_valid_i = 1'b0;
    exp_count    = exp_count + 16'd1;
    check("pkt_count", pkt_count_o, exp_count);
  endtask

  task automatic wait_idle(input string tag);
    bit idle = 1'b0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk_i);
      if (!busy_o) begin idle = 1'b1; break; end
    end
    check({tag, "_drain"}, idle, 1'b1);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_beats"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
    obs_cyc.delete();
  endtask

  initial begin
    bit ok;
    rst_i        = 1'b1;
    desc_valid_i = 1'b0;
    desc_x_i     = '0;
    desc_y_i     = '0;
    desc_len_i   = '0;
    data_valid_i = 1'b0;
    data_i       = '0;
    exp_count    = '0;

    // Reset values.
    @(negedge clk_i);
    check("rst_readies", {desc_ready_o, data_ready_o}, 2'b00);
    @(negedge clk_i);
    check("rst_out", {out_mosi_o.tvalid, out_mosi_o.tdata, out_mosi_o.tlast}, 34'h0);
    check("rst_pkt_count", pkt_count_o, 16'h0);
    check("rst_busy", busy_o, 1'b0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("idle_desc_ready", desc_ready_o, 1'b1);
    check("idle_data_ready", data_ready_o, 1'b0);

    // Single packet, header 0x26 then A1..A3.
    @(posedge clk_i);
    #1;
    send_packet(2'd2, 2'd1, 3'd2, 1'b0);
    wait_idle("single");
    check("single_header_value", obs_q.size() > 0 ? obs_q[0].d : 32'hX, 32'h0000_0026);
    compare_stream("single");

    // Same packet under 1,0,0 backpressure.
    rdy_mode = 1;
    @(posedge clk_i);
    #1;
    send_packet(2'd2, 2'd1, 3'd2, 1'b0);
    wait_idle("backpressure");
    compare_stream("backpressure");
    rdy_mode = 0;

    // Back-to-back len=0 packets must give four consecutive beats.
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    send_packet(2'd1, 2'd3, 3'd0, 1'b1);
    send_packet(2'd0, 2'd0, 3'd0, 1'b1);
    wait_idle("b2b");
    for (int i = 1; i < 4 && i < obs_cyc.size(); i++)
      check($sformatf("b2b_gap%0d", i), obs_cyc[i] - obs_cyc[0], i);
    compare_stream("b2b");

    // Clamp: len=7 becomes 4, then a sixth word must be refused.
    @(posedge clk_i);
    #1;
    send_packet(2'd3, 2'd2, 3'd7, 1'b1);
    data_valid_i = 1'b1;
    data_i       = 32'hDEAD_BEEF;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk_i);
      check($sformatf("clamp_no_extra%0d", t), data_ready_o, 1'b0);
    end
    @(posedge clk_i);
    #1;
    data_valid_i = 1'b0;
    wait_idle("clamp");
    compare_stream("clamp");

    // Randomized packets under random backpressure.
    rdy_mode = 2;
    for (int p = 0; p < 20; p++) begin
      @(posedge clk_i);
      #1;
      send_packet(2'($urandom), 2'($urandom), 3'($urandom), 1'b1);
    end
    wait_idle("random");
    compare_stream("random");
    rdy_mode = 0;

    // Reset in the middle of a packet abandons it.
    @(posedge clk_i);
    #1;
    desc_valid_i = 1'b1;
    desc_x_i     = 2'd1;
    desc_y_i     = 2'd3;
    desc_len_i   = 3'd3;
    ok = 1'b0;
    for (int t = 0; t < BOUND; t++) begin
      @(negedge clk_i);
      if (desc_ready_o) begin ok = 1'b1; break; end
    end
    check("midrst_desc_handshake", ok, 1'b1);
    @(posedge clk_i);
    #1;
    desc_valid_i = 1'b0;
    data_valid_i = 1'b1;
    data_i       = 32'h1234_5678;
    ok = 1'b0;
    for (int t = 0; t < BOUND; t++) begin
      @(negedge clk_i);
      if (data_ready_o) begin ok = 1'b1; break; end
    end
    check("midrst_data_handshake", ok, 1'b1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("midrst_readies", {desc_ready_o, data_ready_o}, 2'b00);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    data_valid_i = 1'b0;
    @(negedge clk_i);
    check("midrst_tvalid", out_mosi_o.tvalid, 1'b0);
    check("midrst_pkt_count", pkt_count_o, 16'h0);
    check("midrst_busy", busy_o, 1'b0);
    check("midrst_idle", desc_ready_o, 1'b1);
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
    exp_count = '0;
    repeat (5) @(negedge clk_i);
    check("midrst_no_beats", obs_q.size(), 0);

    // Counter wrap from 0xFFFF.
    force dut.r_pkt_count = 16'hFFFF;
    @(posedge clk_i);
    #1;
    release dut.r_pkt_count;
    exp_count = 16'hFFFF;
    @(negedge clk_i);
    check("wrap_preload", pkt_count_o, exp_count);
    @(posedge clk_i);
    #1;
    send_packet(2'd0, 2'd1, 3'd1, 1'b1);
    check("wrap_zero", pkt_count_o, 16'h0000);
    wait_idle("wrap");
    compare_stream("wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_packetizer.md
Name: axis_packetizer

Overview:
- Network-interface stage directly upstream of a router local input port.
- Accepts a packet descriptor (target router X/Y, payload length) and a payload word stream.
- Emits one AXIS packet on the router port: one header flit followed by the payload flits, with tlast on the final payload flit.
- The header flit carries the target coordinates that the router arbiter/algorithm stages decode; the packet is held together by tlast.

Parameters:
- DATA_WIDTH, 32, tdata width of payload and header flits.
- MAX_ROUTERS_X, 4, mesh X dimension; MAX_ROUTERS_X_WIDTH = $clog2(MAX_ROUTERS_X).
- MAX_ROUTERS_Y, 4, mesh Y dimension; MAX_ROUTERS_Y_WIDTH = $clog2(MAX_ROUTERS_Y).
- MAXIMUM_PACKAGES_NUMBER, 5, maximum payload flits per packet; LEN_WIDTH = $clog2(MAXIMUM_PACKAGES_NUMBER).

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- desc_valid_i  in  1  descriptor valid.
- desc_ready_o  out  1  descriptor accepted when valid&&ready.
- desc_x_i  in  MAX_ROUTERS_X_WIDTH  target router X.
- desc_y_i  in  MAX_ROUTERS_Y_WIDTH  target router Y.
- desc_len_i  in  LEN_WIDTH  payload flit count minus 1.
- data_valid_i  in  1  payload word valid.
- data_ready_o  out  1  payload word accepted when valid&&ready.
- data_i  in  DATA_WIDTH  payload word.
- out_mosi_o  out  axis_mosi_t  router-side stream (tvalid, tdata, tlast used).
- out_miso_i  in  axis_miso_t  router-side tready.
- pkt_count_o  out  16  packets fully sent, wraps at 0xFFFF->0.
- busy_o  out  1  high whenever state != IDLE or the output register is valid.

Behaviour:
- Reset (rst_i=1 at a clock edge): state=IDLE; out tvalid=0, tdata=0, tlast=0; pkt_count_o=0; flit counter=0; desc_ready_o=0 and data_ready_o=0 during the reset cycle. Reset mid-packet abandons the packet; no tlast is emitted.
- Output register: one stage. load_ok = !out.tvalid || out.tready. A loaded flit stays stable, with tvalid high, until tready. tvalid never drops without a handshake.
- FSM states: IDLE, HEADER, PAYLOAD.
- IDLE: desc_ready_o = load_ok. On descriptor handshake: latch x, y, len. Load the header flit into the output register in the same edge: tdata[X_W-1:0]=x; tdata[X_W+Y_W-1:X_W]=y; tdata[X_W+Y_W+LEN_W-1:X_W+Y_W]=len; upper bits 0; tlast=0. Clear the flit counter and go to PAYLOAD. Header latency: descriptor handshake -> tvalid one cycle later.
- HEADER: reserved state, entered only if the header load is deferred. It loads the header when load_ok and then goes to PAYLOAD. An implementation that always loads in IDLE never enters it.
- PAYLOAD: data_ready_o = load_ok; desc_ready_o=0. Each data handshake loads tdata=data_i into the output register and increments the counter. tlast=1 when counter==len. On that handshake: go to IDLE and increment pkt_count_o.
- Throughput: one flit per cycle when tready stays high. A packet costs len+2 output beats, back-to-back with the next descriptor.
- desc_ready_o and data_ready_o are never high in the same cycle. data_ready_o=0 in IDLE, so payload words cannot leak between packets.
- Backpressure: tready=0 with a valid output holds both ready outputs low, and tdata/tlast stay constant.
- len=0 gives header + one payload flit carrying tlast=1.
- len=MAXIMUM_PACKAGES_NUMBER-1 is the maximum. Values above it are clamped to it, and the clamped value is written in the header.
- X/Y equal to the local router are legal and passed unchanged.
- pkt_count_o increments on the last-payload load edge, not on the output handshake.

Test Plan:
- Reset: hold rst_i 2 cycles during an active packet -> tvalid=0, pkt_count_o=0, busy_o=0, state IDLE on the next cycle.
- Single packet: x=2, y=1, len=2, data A1,A2,A3, tready=1 -> header tdata=0x0000_0026 (x in [1:0], y in [3:2], len in [6:4]), then A1, A2, A3 with tlast only on A3. Total 4 beats, pkt_count_o=1.
- Backpressure: same packet with tready toggling 1,0,0,1,... -> every flit is held stable while stalled, the order is unchanged, and no beat is duplicated or lost.
- Back-to-back: two descriptors, len=0 each, tready=1 -> 4 consecutive beats (H,D,H,D) with tlast on beats 2 and 4, and pkt_count_o=2.
- Clamp: len=7 with MAXIMUM_PACKAGES_NUMBER=5 -> header len field=4, exactly 5 payload flits are accepted, tlast is on the 5th, and the 6th data word is not accepted (data_ready_o=0).
- Counter wrap: preload pkt_count_o=0xFFFF via 65535 packets or force -> the next packet gives 0x0000.
